// File: rtl/iob_axis_word_unpack_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | iob_axis_word_unpack_if : packed-word input and narrow beat output buses   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+

interface iob_axis_word_unpack_in_if #(
  parameter int TDATA_W = 8
);
  localparam int N = 32 / TDATA_W;

  logic [31:0]  tdata;
  logic [N-1:0] tstrb;
  logic         tlast;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, output tstrb, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tstrb, input tlast, input tvalid, output tready);
endinterface

interface iob_axis_word_unpack_out_if #(
  parameter int TDATA_W = 8
);
  logic [TDATA_W-1:0] tdata;
  logic               tlast;
  logic               tvalid;
  logic               tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

`default_nettype wire

// File: rtl/iob_axis_word_unpack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | iob_axis_word_unpack : 32-bit strobed words -> TDATA_W AXI-Stream beats    |
// | Optional strobe check: IOB_AXIS_UNPACK_STRB_CHECK_EN.  Revision 1.0        |
// +----------------------------------------------------------------------------+

module iob_axis_word_unpack #(
  parameter int TDATA_W   = 8,
  parameter int PKT_CNT_W = 16
) (
  input  wire                        clk_i,
  input  wire                        cke_i,
  input  wire                        rst_i,
  input  wire                        enable_i,
  iob_axis_word_unpack_in_if.slave   in_if,
  iob_axis_word_unpack_out_if.master axis_if,
  output logic [PKT_CNT_W-1:0]       pkt_cnt_o,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int N = 32 / TDATA_W;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [0:0]           state_q;
  logic [0:0]           state_d;
  logic [N-1:0]         rem_mask_q;
  logic [N-1:0]         rem_mask_d;
  logic [31:0]          hold_data_q;
  logic                 hold_last_q;
  logic [PKT_CNT_W-1:0] pkt_cnt_q;

  logic [N-1:0]         cur_oh;
  logic                 hold_valid;
  logic                 last_lane;
  logic                 out_tlast;
  logic                 in_hs;
  logic                 out_hs;
  logic [TDATA_W-1:0]   cur_data;

  // Isolate the lowest pending lane as a one-hot select
  assign cur_oh    = rem_mask_q & (~rem_mask_q + N'(1));
  assign last_lane = (rem_mask_q == cur_oh);

  assign in_if.tready = enable_i & (~hold_valid | (axis_if.tready & last_lane));
  assign in_hs        = in_if.tvalid & in_if.tready;
  assign out_hs       = hold_valid & axis_if.tready;

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i) begin
        state_q <= ST_EMPTY;
      end else begin
        state_q <= state_d;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (in_hs) begin
      state_d = (|in_if.tstrb) ? ST_DRAIN : ST_EMPTY;
    end else if (out_hs && last_lane) begin
      state_d = ST_EMPTY;
    end
  end

  always_comb begin
    hold_valid = (state_q == ST_DRAIN);
    out_tlast  = hold_valid & hold_last_q & last_lane;
    busy_o     = hold_valid;
  end

  always_comb begin
    rem_mask_d = rem_mask_q;
    if (in_hs) begin
      rem_mask_d = in_if.tstrb;
    end else if (out_hs) begin
      rem_mask_d = rem_mask_q & ~cur_oh;
    end
  end

  always_comb begin
    cur_data = '0;
    for (int p = 0; p < N; p++) begin
      if (cur_oh[p]) begin
        cur_data = cur_data | hold_data_q[p*TDATA_W +: TDATA_W];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i) begin
        rem_mask_q  <= '0;
        hold_data_q <= '0;
        hold_last_q <= 1'b0;
        pkt_cnt_q   <= '0;
      end else begin
        rem_mask_q <= rem_mask_d;
        if (in_hs) begin
          hold_data_q <= in_if.tdata;
          hold_last_q <= in_if.tlast;
        end
        if (out_hs && out_tlast) begin
          pkt_cnt_q <= pkt_cnt_q + PKT_CNT_W'(1);
        end
      end
    end
  end

  assign axis_if.tvalid = hold_valid;
  assign axis_if.tdata  = cur_data;
  assign axis_if.tlast  = out_tlast;
  assign pkt_cnt_o      = pkt_cnt_q;

`ifdef IOB_AXIS_UNPACK_STRB_CHECK_EN
  logic err_q;
  logic strb_bad;

  // strb & (strb+1) is non-zero exactly when a set lane sits above a clear one
  assign strb_bad = (|(in_if.tstrb & (in_if.tstrb + N'(1)))) | (in_if.tlast & ~(|in_if.tstrb));

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i) begin
        err_q <= 1'b0;
      end else if (in_hs && strb_bad) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_iob_axis_word_unpack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_iob_axis_word_unpack : directed self-checking bench, TDATA_W=8          |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+

module tb_iob_axis_word_unpack;

  localparam int TDATA_W   = 8;
  localparam int PKT_CNT_W = 16;
`ifdef IOB_AXIS_UNPACK_STRB_CHECK_EN
  localparam logic STRB_CHK = 1'b1;
`else
  localparam logic STRB_CHK = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 cke;
  logic                 rst;
  logic                 enable;
  logic [PKT_CNT_W-1:0] pkt_cnt;
  logic                 busy;
  logic                 err;

  int checks = 0;
  int errors = 0;

  iob_axis_word_unpack_in_if  #(.TDATA_W(TDATA_W)) in_if ();
  iob_axis_word_unpack_out_if #(.TDATA_W(TDATA_W)) axis_if ();

  iob_axis_word_unpack #(.TDATA_W(TDATA_W), .PKT_CNT_W(PKT_CNT_W)) dut (
    .clk_i     (clk),
    .cke_i     (cke),
    .rst_i     (rst),
    .enable_i  (enable),
    .in_if     (in_if),
    .axis_if   (axis_if),
    .pkt_cnt_o (pkt_cnt),
    .busy_o    (busy),
    .err_o     (err)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    in_if.tvalid = 1'b0;
    axis_if.tready = 1'b1;
    enable = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    cke = 1'b1; enable = 1'b1; rst = 1'b1;
    in_if.tdata = '0; in_if.tstrb = '0; in_if.tlast = 1'b0; in_if.tvalid = 1'b0;
    axis_if.tready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++; if (axis_if.tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b want 0", axis_if.tvalid); end
    checks++; if (axis_if.tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got %b want 0", axis_if.tlast); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (pkt_cnt !== 16'd0) begin errors++; $display("FAIL rst_pkt_cnt got %0d want 0", pkt_cnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err); end
    checks++; if (in_if.tready !== 1'b1) begin errors++; $display("FAIL rst_in_tready got %b want 1", in_if.tready); end
  endtask

  task automatic test_main();
    logic [7:0] exp_b [6];
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    in_if.tdata = 32'h44332211; in_if.tstrb = 4'hF; in_if.tlast = 1'b0; in_if.tvalid = 1'b1;
    #1;
    checks++; if (in_if.tready !== 1'b1) begin errors++; $display("FAIL main_accept got %b want 1", in_if.tready); end
    @(posedge clk); #1;
    in_if.tdata = 32'h88776655; in_if.tstrb = 4'h3; in_if.tlast = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if (axis_if.tvalid !== 1'b1) begin errors++; $display("FAIL main_tvalid beat %0d got %b want 1", i, axis_if.tvalid); end
      checks++; if (axis_if.tdata !== exp_b[i]) begin errors++; $display("FAIL main_tdata beat %0d got %h want %h", i, axis_if.tdata, exp_b[i]); end
      checks++; if (axis_if.tlast !== (i == 5)) begin errors++; $display("FAIL main_tlast beat %0d got %b want %b", i, axis_if.tlast, (i == 5)); end
      checks++; if (in_if.tready !== (i == 3 || i == 5)) begin errors++; $display("FAIL main_in_tready beat %0d got %b want %b", i, in_if.tready, (i == 3 || i == 5)); end
      @(posedge clk); #1;
      if (i == 3) in_if.tvalid = 1'b0;
    end
    #1;
    checks++; if (axis_if.tvalid !== 1'b0) begin errors++; $display("FAIL main_end_tvalid got %b want 0", axis_if.tvalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL main_end_busy got %b want 0", busy); end
    checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL main_pkt_cnt got %0d want 1", pkt_cnt); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_b [4];
    logic       rdy [8];
    int         idx;
    exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    rdy   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    idx   = 0;
    do_reset();
    in_if.tdata = 32'hDDCCBBAA; in_if.tstrb = 4'hF; in_if.tlast = 1'b0; in_if.tvalid = 1'b1;
    @(posedge clk); #1;
    in_if.tdata = 32'h0000005A; in_if.tstrb = 4'h1; in_if.tlast = 1'b1;
    for (int c = 0; c < 8 && idx < 4; c++) begin
      axis_if.tready = rdy[c];
      #1;
      checks++; if (axis_if.tvalid !== 1'b1) begin errors++; $display("FAIL bp_tvalid cyc %0d got %b want 1", c, axis_if.tvalid); end
      checks++; if (axis_if.tdata !== exp_b[idx]) begin errors++; $display("FAIL bp_tdata cyc %0d got %h want %h", c, axis_if.tdata, exp_b[idx]); end
      checks++; if (in_if.tready !== (idx == 3 && rdy[c])) begin errors++; $display("FAIL bp_in_tready cyc %0d got %b want %b", c, in_if.tready, (idx == 3 && rdy[c])); end
      @(posedge clk); #1;
      if (rdy[c]) idx++;
    end
    checks++; if (idx != 4) begin errors++; $display("FAIL bp_timeout beats %0d want 4", idx); end
    in_if.tvalid = 1'b0; axis_if.tready = 1'b1;
    #1;
    checks++; if (axis_if.tdata !== 8'h5A) begin errors++; $display("FAIL bp_next_tdata got %h want 5a", axis_if.tdata); end
    checks++; if (axis_if.tlast !== 1'b1) begin errors++; $display("FAIL bp_next_tlast got %b want 1", axis_if.tlast); end
    @(posedge clk); #1;
    checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL bp_pkt_cnt got %0d want 1", pkt_cnt); end
    checks++; if (axis_if.tvalid !== 1'b0) begin errors++; $display("FAIL bp_end_tvalid got %b want 0", axis_if.tvalid); end
  endtask

  task automatic test_zero_strobe();
    in_if.tdata = 32'hFFFFFFFF; in_if.tstrb = 4'h0; in_if.tlast = 1'b1; in_if.tvalid = 1'b1;
    #1;
    checks++; if (in_if.tready !== 1'b1) begin errors++; $display("FAIL zs_in_tready got %b want 1", in_if.tready); end
    @(posedge clk); #1;
    in_if.tvalid = 1'b0;
    #1;
    checks++; if (axis_if.tvalid !== 1'b0) begin errors++; $display("FAIL zs_tvalid got %b want 0", axis_if.tvalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zs_busy got %b want 0", busy); end
    checks++; if (err !== STRB_CHK) begin errors++; $display("FAIL zs_err got %b want %b", err, STRB_CHK); end
    @(posedge clk); #1;
    checks++; if (axis_if.tvalid !== 1'b0) begin errors++; $display("FAIL zs_tvalid2 got %b want 0", axis_if.tvalid); end
    checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL zs_pkt_cnt got %0d want 1", pkt_cnt); end
  endtask

  task automatic test_noncontig();
    do_reset();
    in_if.tdata = 32'h04030201; in_if.tstrb = 4'b0101; in_if.tlast = 1'b1; in_if.tvalid = 1'b1;
    @(posedge clk); #1;
    in_if.tvalid = 1'b0;
    #1;
    checks++; if (axis_if.tdata !== 8'h01) begin errors++; $display("FAIL nc_beat0 got %h want 01", axis_if.tdata); end
    checks++; if (axis_if.tlast !== 1'b0) begin errors++; $display("FAIL nc_tlast0 got %b want 0", axis_if.tlast); end
    checks++; if (err !== STRB_CHK) begin errors++; $display("FAIL nc_err got %b want %b", err, STRB_CHK); end
    @(posedge clk); #1;
    checks++; if (axis_if.tdata !== 8'h03) begin errors++; $display("FAIL nc_beat1 got %h want 03", axis_if.tdata); end
    checks++; if (axis_if.tlast !== 1'b1) begin errors++; $display("FAIL nc_tlast1 got %b want 1", axis_if.tlast); end
    @(posedge clk); #1;
    checks++; if (axis_if.tvalid !== 1'b0) begin errors++; $display("FAIL nc_end_tvalid got %b want 0", axis_if.tvalid); end
    checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL nc_pkt_cnt got %0d want 1", pkt_cnt); end
  endtask

  task automatic test_reset_midword();
    in_if.tdata = 32'h0D0C0B0A; in_if.tstrb = 4'hF; in_if.tlast = 1'b1; in_if.tvalid = 1'b1;
    @(posedge clk); #1;
    in_if.tvalid = 1'b0;
    #1;
    checks++; if (axis_if.tdata !== 8'h0A) begin errors++; $display("FAIL rm_beat0 got %h want 0a", axis_if.tdata); end
    @(posedge clk); #1;
    checks++; if (axis_if.tdata !== 8'h0B) begin errors++; $display("FAIL rm_beat1 got %h want 0b", axis_if.tdata); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (axis_if.tvalid !== 1'b0) begin errors++; $display("FAIL rm_tvalid got %b want 0", axis_if.tvalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b want 0", busy); end
    checks++; if (pkt_cnt !== 16'd0) begin errors++; $display("FAIL rm_pkt_cnt got %0d want 0", pkt_cnt); end
    in_if.tdata = 32'h14131211; in_if.tstrb = 4'hF; in_if.tlast = 1'b1; in_if.tvalid = 1'b1;
    @(posedge clk); #1;
    in_if.tvalid = 1'b0;
    #1;
    checks++; if (axis_if.tdata !== 8'h11) begin errors++; $display("FAIL rm_restart got %h want 11", axis_if.tdata); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL rm_restart_pkt got %0d want 1", pkt_cnt); end
  endtask

  task automatic test_enable();
    do_reset();
    enable = 1'b0;
    in_if.tdata = 32'h24232221; in_if.tstrb = 4'hF; in_if.tlast = 1'b1; in_if.tvalid = 1'b1;
    #1;
    checks++; if (in_if.tready !== 1'b0) begin errors++; $display("FAIL en_blocked got %b want 0", in_if.tready); end
    @(posedge clk); #1;
    checks++; if (axis_if.tvalid !== 1'b0) begin errors++; $display("FAIL en_noload got %b want 0", axis_if.tvalid); end
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    in_if.tdata = 32'h00000099; in_if.tstrb = 4'h1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (axis_if.tdata !== 8'(8'h21 + i)) begin errors++; $display("FAIL en_drain beat %0d got %h want %h", i, axis_if.tdata, 8'(8'h21 + i)); end
      checks++; if (in_if.tready !== 1'b0) begin errors++; $display("FAIL en_drain_tready beat %0d got %b want 0", i, in_if.tready); end
      @(posedge clk); #1;
    end
    checks++; if (axis_if.tvalid !== 1'b0) begin errors++; $display("FAIL en_end_tvalid got %b want 0", axis_if.tvalid); end
    checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL en_pkt_cnt got %0d want 1", pkt_cnt); end
    in_if.tvalid = 1'b0;
    enable = 1'b1;
  endtask

  task automatic test_wrap();
    do_reset();
    in_if.tdata = 32'h00000077; in_if.tstrb = 4'h1; in_if.tlast = 1'b1; in_if.tvalid = 1'b1;
    repeat (65535) @(posedge clk);
    #1 in_if.tvalid = 1'b0;
    @(posedge clk); #1;
    checks++; if (pkt_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_max got %h want ffff", pkt_cnt); end
    checks++; if (axis_if.tvalid !== 1'b0) begin errors++; $display("FAIL wrap_idle got %b want 0", axis_if.tvalid); end
    in_if.tvalid = 1'b1;
    @(posedge clk); #1;
    in_if.tvalid = 1'b0;
    #1;
    checks++; if (axis_if.tlast !== 1'b1) begin errors++; $display("FAIL wrap_tlast got %b want 1", axis_if.tlast); end
    @(posedge clk); #1;
    checks++; if (pkt_cnt !== 16'd0) begin errors++; $display("FAIL wrap_zero got %h want 0000", pkt_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrap_busy got %b want 0", busy); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_main();
    test_backpressure();
    test_zero_strobe();
    test_noncontig();
    test_reset_midword();
    test_enable();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
